// File: rtl/terrain_ram_arbiter.sv
// ============================================================================
// terrain_ram_arbiter : shares the 1-bit terrain RAM between LFSR fill, video
//                       reads and gameplay writes.   Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module terrain_ram_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int FILL_COUNT  = 3600,
  parameter int RAM_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  fill_start_in,
  input  logic [15:0]           fill_seed_in,
  output logic                  fill_busy_out,
  output logic                  fill_done_out,
  input  logic                  vid_active_in,
  input  logic [ADDR_WIDTH-1:0] vid_addr_in,
  output logic                  vid_data_out,
  output logic                  vid_valid_out,
  input  logic                  wr_valid_in,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic                  wr_data_in,
  output logic                  wr_ready_out,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  output logic                  ram_din_out,
  output logic                  ram_we_out,
  input  logic                  ram_dout_in
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  localparam logic [15:0]           c_SEED_DEFAULT = 16'hACE1;
  localparam int                    c_VPIPE        = 1 + RAM_LATENCY;
  localparam logic [ADDR_WIDTH-1:0] c_LAST         = ADDR_WIDTH'(FILL_COUNT - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_counter;
  logic [15:0]             r_lfsr;
  logic [ADDR_WIDTH-1:0]   r_ram_addr;
  logic                    r_ram_din;
  logic                    r_ram_we;
  logic                    r_done;
  logic [c_VPIPE-1:0]      r_vpipe;

  logic [ADDR_WIDTH-1:0]   w_ram_addr_nxt;
  logic                    w_ram_din_nxt;
  logic                    w_ram_we_nxt;
  logic                    w_grant_vid;
  logic                    w_start;
  logic                    w_fill_last;
  logic [15:0]             w_lfsr_step;

  assign w_start     = (r_state == S_IDLE) && fill_start_in;
  assign w_grant_vid = (r_state == S_IDLE) && vid_active_in;
  assign w_fill_last = (r_state == S_FILL) && (r_counter == c_LAST);
  assign w_lfsr_step = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

  always_comb begin
    w_state_nxt    = r_state;
    w_ram_addr_nxt = r_ram_addr;
    w_ram_din_nxt  = r_ram_din;
    w_ram_we_nxt   = 1'b0;
    case (r_state)
      S_FILL: begin
        w_ram_addr_nxt = r_counter;
        w_ram_din_nxt  = r_lfsr[0];
        w_ram_we_nxt   = 1'b1;
        if (w_fill_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        if (fill_start_in) begin
          w_state_nxt = S_FILL;
        end
        // Video outranks gameplay; a same-cycle fill start still lets the write through.
        if (vid_active_in) begin
          w_ram_addr_nxt = vid_addr_in;
        end else if (wr_valid_in) begin
          w_ram_addr_nxt = wr_addr_in;
          w_ram_din_nxt  = wr_data_in;
          w_ram_we_nxt   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_counter  <= '0;
      r_lfsr     <= c_SEED_DEFAULT;
      r_ram_addr <= '0;
      r_ram_din  <= 1'b0;
      r_ram_we   <= 1'b0;
      r_done     <= 1'b0;
      r_vpipe    <= '0;
    end else begin
      r_ram_addr <= w_ram_addr_nxt;
      r_ram_din  <= w_ram_din_nxt;
      r_ram_we   <= w_ram_we_nxt;
      r_done     <= w_fill_last;
      r_vpipe    <= {r_vpipe[c_VPIPE-2:0], w_grant_vid};
      if (w_start) begin
        r_counter <= '0;
        r_lfsr    <= (fill_seed_in == 16'h0000) ? c_SEED_DEFAULT : fill_seed_in;
      end else if (r_state == S_FILL) begin
        r_lfsr <= w_lfsr_step;
        if (!w_fill_last) begin
          r_counter <= r_counter + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign fill_busy_out = (r_state == S_FILL);
  assign fill_done_out = r_done;
  assign wr_ready_out  = (r_state == S_IDLE) && !vid_active_in;
  assign vid_data_out  = ram_dout_in;
  assign vid_valid_out = r_vpipe[c_VPIPE-1];
  assign ram_addr_out  = r_ram_addr;
  assign ram_din_out   = r_ram_din;
  assign ram_we_out    = r_ram_we;

endmodule

`default_nettype wire

// File: tb/tb_terrain_ram_arbiter.sv
// ============================================================================
// tb_terrain_ram_arbiter : directed bench with a 2-cycle read-first RAM model.
//                          Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_terrain_ram_arbiter;

  localparam int FC = 3600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fill_start = 1'b0;
  logic [15:0] fill_seed = '0;
  logic        fill_busy, fill_done;
  logic        vid_active = 1'b0;
  logic [15:0] vid_addr = '0;
  logic        vid_data, vid_valid;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_addr = '0;
  logic        wr_data = 1'b0;
  logic        wr_ready;
  logic [15:0] ram_addr;
  logic        ram_din, ram_we;
  logic        ram_dout;

  int n_vec = 0;
  int n_err = 0;

  logic ram_mem [0:65535];
  logic ram_q1 = 1'b0;
  logic exp_mem [0:4095];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_q1   <= ram_mem[ram_addr];
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_q1;
  end

  terrain_ram_arbiter #(
    .ADDR_WIDTH (16),
    .FILL_COUNT (FC),
    .RAM_LATENCY(2)
  ) u_dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .fill_start_in(fill_start),
    .fill_seed_in (fill_seed),
    .fill_busy_out(fill_busy),
    .fill_done_out(fill_done),
    .vid_active_in(vid_active),
    .vid_addr_in  (vid_addr),
    .vid_data_out (vid_data),
    .vid_valid_out(vid_valid),
    .wr_valid_in  (wr_valid),
    .wr_addr_in   (wr_addr),
    .wr_data_in   (wr_data),
    .wr_ready_out (wr_ready),
    .ram_addr_out (ram_addr),
    .ram_din_out  (ram_din),
    .ram_we_out   (ram_we),
    .ram_dout_in  (ram_dout)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  task automatic run_fill(input logic [15:0] seed, input bit restart);
    logic [15:0] m;
    int writes, aerr, derr, dcnt, dcyc, bcyc;
    fill_seed  = seed;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    fill_seed  = 16'h0;
    chk_eq("fill_busy_rise", fill_busy, 1);
    #1;
    chk_eq("fill_wr_ready", wr_ready, 0);
    m = (seed == 16'h0) ? 16'hACE1 : seed;
    writes = 0; aerr = 0; derr = 0; dcnt = 0; dcyc = 0; bcyc = 1;
    for (int k = 2; k <= FC + 10; k++) begin
      if (restart && k == 200) begin
        fill_start = 1'b1;
        fill_seed  = 16'h1234;
      end
      tick();
      fill_start = 1'b0;
      if (fill_busy) bcyc++;
      if (ram_we) begin
        if (ram_addr != 16'(writes)) aerr++;
        if (ram_din != m[0]) derr++;
        if (writes < 4096) exp_mem[writes] = m[0];
        m = lfsr_next(m);
        writes++;
      end
      if (fill_done) begin
        dcnt++;
        dcyc = k;
      end
    end
    chk_eq("fill_writes", writes, FC);
    chk_eq("fill_addr_errs", aerr, 0);
    chk_eq("fill_data_errs", derr, 0);
    chk_eq("fill_done_count", dcnt, 1);
    chk_eq("fill_done_cycle", dcyc, FC + 1);
    chk_eq("fill_busy_cycles", bcyc, FC);
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic expv);
    repeat (3) tick();
    vid_addr   = a;
    vid_active = 1'b1;
    tick();
    vid_active = 1'b0;
    chk_eq({tag, "_addr"}, ram_addr, a);
    tick();
    chk_eq({tag, "_early"}, vid_valid, 0);
    tick();
    chk_eq({tag, "_valid"}, vid_valid, 1);
    chk_eq({tag, "_data"}, vid_data, expv);
  endtask

  task automatic do_write(input logic [15:0] a, input logic d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    #1;
    chk_eq("wr_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    chk_eq("wr_we", ram_we, 1);
    chk_eq("wr_addr", ram_addr, a);
    chk_eq("wr_din", ram_din, d);
    if (a < 16'd4096) exp_mem[a] = d;
  endtask

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int bad, webad, donebad;
    logic [15:0] a;

    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_flags", {fill_busy, fill_done, ram_we, ram_din, vid_valid}, 5'b0);
    chk_eq("rst_addr", ram_addr, 16'h0);
    rst = 1'b0;
    #1;
    chk_eq("rst_ready", wr_ready, 1);
    vid_active = 1'b1;
    #1;
    chk_eq("ready_vid_block", wr_ready, 0);
    vid_active = 1'b0;
    tick();

    // Reset while the fill counter sits at 100.
    fill_seed  = 16'h0BAD;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    repeat (100) tick();
    chk_eq("midfill_addr_before", ram_addr, 16'd99);
    #2;
    rst = 1'b1;
    #1;
    chk_eq("midfill_rst_flags", {fill_busy, fill_done, ram_we, ram_din, vid_valid}, 5'b0);
    chk_eq("midfill_rst_addr", ram_addr, 16'h0);
    tick();
    tick();
    rst = 1'b0;
    webad = 0; donebad = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ram_we) webad++;
      if (fill_done) donebad++;
      if (fill_busy) bad++;
    end
    chk_eq("midfill_no_writes", webad, 0);
    chk_eq("midfill_no_done", donebad, 0);
    chk_eq("midfill_no_busy", bad, 0);

    run_fill(16'h0000, 1'b0);
    read_chk("rd5", 16'd5, exp_mem[5]);
    read_chk("rd_last", 16'(FC - 1), exp_mem[FC - 1]);

    do_write(16'd42, 1'b0);
    read_chk("rd42_zero", 16'd42, 1'b0);

    // Write held off by ten cycles of video.
    wr_valid   = 1'b1;
    wr_addr    = 16'd42;
    wr_data    = 1'b1;
    vid_active = 1'b1;
    vid_addr   = 16'd7;
    bad = 0; webad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (wr_ready) bad++;
      tick();
      if (ram_we) webad++;
    end
    chk_eq("held_ready_low", bad, 0);
    chk_eq("held_no_write", webad, 0);
    vid_active = 1'b0;
    #1;
    chk_eq("held_ready_rise", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    chk_eq("held_we", ram_we, 1);
    chk_eq("held_addr", ram_addr, 16'd42);
    chk_eq("held_din", ram_din, 1);
    exp_mem[42] = 1'b1;
    read_chk("rd42_one", 16'd42, 1'b1);

    run_fill(16'h5A5A, 1'b1);
    read_chk("rd5_seeded", 16'd5, exp_mem[5]);

    // Alternating read/write slots; only read slots may be tagged valid.
    for (int k = 0; k < 20; k++) begin
      vid_active = 1'b0;
      wr_valid   = 1'b0;
      if (k < 16) begin
        if (k % 2 == 0) begin
          vid_active = 1'b1;
          vid_addr   = 16'(300 + k);
        end else begin
          a          = 16'(500 + k);
          wr_valid   = 1'b1;
          wr_addr    = a;
          wr_data    = ~exp_mem[a];
          exp_mem[a] = wr_data;
        end
      end
      tick();
      if (k >= 2 && k - 2 < 16 && (k - 2) % 2 == 0) begin
        chk_eq("alt_valid", vid_valid, 1);
        chk_eq("alt_data", vid_data, exp_mem[300 + k - 2]);
      end else begin
        chk_eq("alt_valid", vid_valid, 0);
      end
    end
    vid_active = 1'b0;
    wr_valid   = 1'b0;
    read_chk("rd501", 16'd501, exp_mem[501]);
    read_chk("rd515", 16'd515, exp_mem[515]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
